// File: rtl/lstm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lstm_pkg
// Description : Types and constants shared by the LSTM blocks: default
//               vector geometry, the element type, the h-collector FSM
//               state enum, and a small sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lstm_pkg;

    localparam int LSTM_FEATURES     = 4;
    localparam int LSTM_ELEMENT_BITS = 8;

    typedef logic [LSTM_ELEMENT_BITS-1:0] lstm_elem_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        PEND = 2'd3
    } hcol_state_t;

    // Largest of three values; used to size the shared counter width.
    function automatic int hcol_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lstm_sync2
// Description : Two-flop synchronizer followed by a registered rising-edge
//               detector. A low-to-high level change on i_level produces a
//               single-cycle o_rise pulse.
// Ports       : clk     - destination clock
//               rst_n   - asynchronous active-low reset
//               i_level - asynchronous level input
//               o_rise  - one-cycle pulse on a synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_meta   <= i_level;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_rise   <= r_sync & ~r_sync_d;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/lstm_h_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lstm_h_collector
// Description : Collects the hidden state h_t streamed by lstm_cell. A rising
//               edge on done_wr (cell clock domain) triggers a read_output
//               request pulse; FEATURES serial elements are then captured
//               into a shadow register and handed to the consumer through a
//               valid/ready slot. One further vector may wait in the shadow
//               while the output slot is occupied.
// Ports       : sys_clk     - sole clock
//               reset_n     - asynchronous active-low reset
//               done_wr     - h_t ready level from lstm_cell (async)
//               read_output - stream request to lstm_cell
//               h_curr_ser  - serial element input, element 0 first
//               h_vec       - packed h_t, element i at [i*EB +: EB]
//               h_valid     - h_vec holds an unconsumed vector
//               h_ready     - consumer accept
//               busy        - FSM not idle
//               ovf_cnt     - saturating count of dropped requests
//                             (only with LSTM_HCOL_OVF_CNT_EN defined)
// Options     : LSTM_HCOL_OVF_CNT_EN - adds the ovf_cnt port and counter
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_h_collector
    import lstm_pkg::*;
#(
    parameter int FEATURES     = LSTM_FEATURES,
    parameter int ELEMENT_BITS = LSTM_ELEMENT_BITS,
    parameter int RD_PULSE     = 4,
    parameter int RD_LAT       = 1
) (
    input  logic                             sys_clk,
    input  logic                             reset_n,
    input  logic                             done_wr,
    output logic                             read_output,
    input  logic [ELEMENT_BITS-1:0]          h_curr_ser,
    output logic [FEATURES*ELEMENT_BITS-1:0] h_vec,
    output logic                             h_valid,
    input  logic                             h_ready,
    output logic                             busy
`ifdef LSTM_HCOL_OVF_CNT_EN
   ,output logic [7:0]                       ovf_cnt
`endif
);

    localparam int C_CNT_W = $clog2(hcol_max3(RD_PULSE, RD_LAT + 1, FEATURES) + 1);
    localparam int C_VEC_W = FEATURES * ELEMENT_BITS;

    typedef logic [C_CNT_W-1:0] cnt_t;

    localparam cnt_t C_PULSE_LAST = cnt_t'(RD_PULSE);
    localparam cnt_t C_LAT_LAST   = (RD_LAT > 0) ? cnt_t'(RD_LAT - 1) : '0;
    localparam cnt_t C_ELEM_LAST  = cnt_t'(FEATURES - 1);

    hcol_state_t        r_state;
    cnt_t               r_pcnt;
    cnt_t               r_lcnt;
    cnt_t               r_idx;
    logic               r_read_output;
    logic [C_VEC_W-1:0] r_shadow;
    logic [C_VEC_W-1:0] r_vec;
    logic               r_valid;

    logic               w_rise;
    logic               w_slot_free;
    logic [C_VEC_W-1:0] w_shadow_next;

    lstm_sync2 u_sync_done (
        .clk     (sys_clk),
        .rst_n   (reset_n),
        .i_level (done_wr),
        .o_rise  (w_rise)
    );

    // The output slot can take a new vector if empty or being consumed now.
    assign w_slot_free = ~r_valid | h_ready;

    // Shadow contents including the element arriving this cycle, so the last
    // element can go straight to h_vec without an extra cycle.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int i = 0; i < FEATURES; i++) begin
            if (r_idx == cnt_t'(i)) begin
                w_shadow_next[i*ELEMENT_BITS +: ELEMENT_BITS] = h_curr_ser;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pcnt        <= '0;
            r_lcnt        <= '0;
            r_idx         <= '0;
            r_read_output <= 1'b0;
            r_shadow      <= '0;
            r_vec         <= '0;
            r_valid       <= 1'b0;
        end else begin
            // The request pulse runs its full length even after capture
            // has started, so it is timed independently of the state.
            if (r_read_output) begin
                if (r_pcnt == C_PULSE_LAST) begin
                    r_read_output <= 1'b0;
                    r_pcnt        <= '0;
                end else begin
                    r_pcnt <= r_pcnt + cnt_t'(1);
                end
            end

            if (r_valid && h_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_read_output <= 1'b1;
                        r_pcnt        <= cnt_t'(1);
                        r_lcnt        <= '0;
                        r_idx         <= '0;
                        // Zero latency means element 0 is on the bus in the
                        // very first request cycle.
                        r_state       <= (RD_LAT == 0) ? CAPT : REQ;
                    end
                end
                REQ: begin
                    if (r_lcnt == C_LAT_LAST) begin
                        r_state <= CAPT;
                    end else begin
                        r_lcnt <= r_lcnt + cnt_t'(1);
                    end
                end
                CAPT: begin
                    r_shadow <= w_shadow_next;
                    if (r_idx == C_ELEM_LAST) begin
                        r_idx <= '0;
                        if (w_slot_free) begin
                            r_vec   <= w_shadow_next;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_state <= PEND;
                        end
                    end else begin
                        r_idx <= r_idx + cnt_t'(1);
                    end
                end
                PEND: begin
                    if (w_slot_free) begin
                        r_vec   <= r_shadow;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LSTM_HCOL_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    // A rise outside IDLE is a dropped request; count it, saturating.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_cnt <= 8'h00;
        end else if (w_rise && (r_state != IDLE) && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    assign read_output = r_read_output;
    assign h_vec       = r_vec;
    assign h_valid     = r_valid;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lstm_h_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lstm_h_collector
// Description : Self-checking bench for lstm_h_collector. Two instances are
//               driven from shared done_wr/h_ready: instance 0 with
//               RD_LAT=1/RD_PULSE=4, instance 1 with RD_LAT=0/RD_PULSE=1.
//               A transaction-level timing model predicts every output on
//               every cycle; directed scenarios add literal expectations.
// Options     : LSTM_HCOL_OVF_CNT_EN - also checks ovf_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_h_collector;
    import lstm_pkg::*;

    localparam int F  = 4;
    localparam int EB = 8;
    localparam int VW = F * EB;
    localparam int NI = 2;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction
    function automatic int pulse_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    logic           clk = 1'b0;
    logic           reset_n;
    logic           done_wr;
    logic           h_ready;
    lstm_elem_t     hser   [NI];
    logic [NI-1:0]  d_rd;
    logic [NI-1:0]  d_valid;
    logic [NI-1:0]  d_busy;
    logic [VW-1:0]  d_vec  [NI];
`ifdef LSTM_HCOL_OVF_CNT_EN
    logic [7:0]     d_ovf  [NI];
`endif

    always #5 clk = ~clk;

    lstm_h_collector #(.FEATURES(F), .ELEMENT_BITS(EB), .RD_PULSE(4), .RD_LAT(1)) u_dut0 (
        .sys_clk     (clk),
        .reset_n     (reset_n),
        .done_wr     (done_wr),
        .read_output (d_rd[0]),
        .h_curr_ser  (hser[0]),
        .h_vec       (d_vec[0]),
        .h_valid     (d_valid[0]),
        .h_ready     (h_ready),
        .busy        (d_busy[0])
`ifdef LSTM_HCOL_OVF_CNT_EN
       ,.ovf_cnt     (d_ovf[0])
`endif
    );

    lstm_h_collector #(.FEATURES(F), .ELEMENT_BITS(EB), .RD_PULSE(1), .RD_LAT(0)) u_dut1 (
        .sys_clk     (clk),
        .reset_n     (reset_n),
        .done_wr     (done_wr),
        .read_output (d_rd[1]),
        .h_curr_ser  (hser[1]),
        .h_vec       (d_vec[1]),
        .h_valid     (d_valid[1]),
        .h_ready     (h_ready),
        .busy        (d_busy[1])
`ifdef LSTM_HCOL_OVF_CNT_EN
       ,.ovf_cnt     (d_ovf[1])
`endif
    );

    // ---------------- reference model (edge-indexed transactions) ----------
    int            e;              // index of the most recent clock edge
    bit            dh [5];         // done_wr samples, dh[k] = sample at edge e-k
    int            S      [NI];    // edge at which the current request was accepted
    bit            m_busy [NI];
    bit            m_pend [NI];
    bit            m_valid[NI];
    logic [VW-1:0] m_vec  [NI];
    logic [EB-1:0] m_buf  [NI][F];
    int            m_ovf  [NI];

    int            n_cmp;
    int            n_err;
    int            n_rise [NI];
    int            n_hi   [NI];
    bit            prev_rd[NI];
    bit            use_tbl;
    logic [EB-1:0] tbl    [NI][F];

    task automatic model_reset(input int i);
        S[i]       = -1000;
        m_busy[i]  = 1'b0;
        m_pend[i]  = 1'b0;
        m_valid[i] = 1'b0;
        m_vec[i]   = '0;
        m_ovf[i]   = 0;
        for (int k = 0; k < F; k++) m_buf[i][k] = '0;
    endtask

    // Element index sampled at the coming edge, or -1 if none.
    function automatic int next_cap_idx(input int i);
        int j;
        if (!m_busy[i] || m_pend[i]) return -1;
        j = (e + 1) - (S[i] + 1 + lat_of(i));
        return (j >= 0 && j < F) ? j : -1;
    endfunction

    task automatic model_step(input int i);
        bit rise, free, load;
        int j;
        rise = dh[3] && !dh[4];   // request reaches the FSM three edges after sampling
        free = !m_valid[i] || h_ready;
        load = 1'b0;
        if (m_busy[i]) begin
            if (!m_pend[i]) begin
                j = e - (S[i] + 1 + lat_of(i));
                if (j >= 0 && j < F) m_buf[i][j] = hser[i];
                if (j == F - 1) begin
                    if (free) begin load = 1'b1; m_busy[i] = 1'b0; end
                    else m_pend[i] = 1'b1;
                end
            end else if (free) begin
                load = 1'b1; m_busy[i] = 1'b0; m_pend[i] = 1'b0;
            end
            if (rise && m_ovf[i] < 255) m_ovf[i]++;
        end else if (rise) begin
            S[i] = e; m_busy[i] = 1'b1; m_pend[i] = 1'b0;
        end
        if (load) begin
            for (int k = 0; k < F; k++) m_vec[i][k*EB +: EB] = m_buf[i][k];
            m_valid[i] = 1'b1;
        end else if (m_valid[i] && h_ready) begin
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] t=%0t: got %h, expected %h", nm, i, $time, act, exp);
        end
    endtask

    // One clock: drive data, advance the model across the edge, then compare.
    task automatic tick();
        int c;
        for (int i = 0; i < NI; i++) begin
            c = next_cap_idx(i);
            hser[i] = (use_tbl && c >= 0) ? tbl[i][c] : EB'($urandom);
        end
        e++;
        if (!reset_n) begin
            for (int k = 0; k < 5; k++) dh[k] = 1'b0;
            for (int i = 0; i < NI; i++) model_reset(i);
        end else begin
            for (int k = 4; k > 0; k--) dh[k] = dh[k-1];
            dh[0] = done_wr;
            for (int i = 0; i < NI; i++) model_step(i);
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("read_output", i, 32'(d_rd[i]),
                32'((e >= S[i]) && (e < S[i] + pulse_of(i))));
            chk("busy",    i, 32'(d_busy[i]),  32'(m_busy[i]));
            chk("h_valid", i, 32'(d_valid[i]), 32'(m_valid[i]));
            chk("h_vec",   i, d_vec[i],        m_vec[i]);
`ifdef LSTM_HCOL_OVF_CNT_EN
            chk("ovf_cnt", i, 32'(d_ovf[i]),   32'(m_ovf[i]));
`endif
            if (d_rd[i] && !prev_rd[i]) n_rise[i]++;
            if (d_rd[i]) n_hi[i]++;
            prev_rd[i] = d_rd[i];
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_tbl(input logic [31:0] v0, input logic [31:0] v1);
        for (int k = 0; k < F; k++) begin
            tbl[0][k] = v0[k*EB +: EB];
            tbl[1][k] = v1[k*EB +: EB];
        end
    endtask

    task automatic clr_rd_stats();
        for (int i = 0; i < NI; i++) begin n_rise[i] = 0; n_hi[i] = 0; end
    endtask

    task automatic chk_all_zero(input string nm);
        for (int i = 0; i < NI; i++) begin
            chk({nm, "_read_output"}, i, 32'(d_rd[i]),    32'd0);
            chk({nm, "_h_valid"},     i, 32'(d_valid[i]), 32'd0);
            chk({nm, "_h_vec"},       i, d_vec[i],        32'd0);
            chk({nm, "_busy"},        i, 32'(d_busy[i]),  32'd0);
        end
    endtask

    initial begin
        bit hit;
        n_cmp = 0; n_err = 0; e = 0; use_tbl = 1'b1;
        reset_n = 1'b0; done_wr = 1'b0; h_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin hser[i] = '0; prev_rd[i] = 1'b0; model_reset(i); end
        for (int k = 0; k < 5; k++) dh[k] = 1'b0;
        clr_rd_stats();

        // Reset for 90 ns.
        repeat (9) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Basic capture.
        set_tbl(32'h44332211, 32'h04030201);
        done_wr = 1'b1;
        run(14);
        chk("basic_vec",    0, d_vec[0],          32'h44332211);
        chk("basic_model",  0, m_vec[0],          32'h44332211);
        chk("basic_valid",  0, 32'(d_valid[0]),   32'd1);
        chk("basic_rd_hi",  0, 32'(n_hi[0]),      32'd4);
        chk("lat0_vec",     1, d_vec[1],          32'h04030201);
        chk("lat0_rd_hi",   1, 32'(n_hi[1]),      32'd1);

        // Backpressure: second vector parks in the shadow.
        done_wr = 1'b0;
        run(5);
        set_tbl(32'hDDCCBBAA, 32'hDDCCBBAA);
        done_wr = 1'b1;
        run(14);
        chk("bp_pend_busy", 0, 32'(d_busy[0]),    32'd1);
        chk("bp_hold_vec",  0, d_vec[0],          32'h44332211);
        chk("bp_hold_vec",  1, d_vec[1],          32'h04030201);
        h_ready = 1'b1;
        run(1);
        h_ready = 1'b0;
        chk("bp_load_vec",  0, d_vec[0],          32'hDDCCBBAA);
        chk("bp_load_val",  0, 32'(d_valid[0]),   32'd1);
        chk("bp_idle",      0, 32'(d_busy[0]),    32'd0);
        h_ready = 1'b1;
        run(1);
        chk("accept_clear", 0, 32'(d_valid[0]),   32'd0);

        // Overrun: a second rise during capture is dropped.
        done_wr = 1'b0;
        run(5);
        clr_rd_stats();
        set_tbl(32'h88776655, 32'h88776655);
        done_wr = 1'b1; run(2);
        done_wr = 1'b0; run(1);
        done_wr = 1'b1; run(12);
        for (int i = 0; i < NI; i++) begin
            chk("ovr_rd_pulses", i, 32'(n_rise[i]), 32'd1);
            chk("ovr_vec",       i, d_vec[i],       32'h88776655);
`ifdef LSTM_HCOL_OVF_CNT_EN
            chk("ovr_ovf_cnt",   i, 32'(d_ovf[i]),  32'd1);
`endif
        end

        // Reset after two elements of instance 0.
        h_ready = 1'b0;
        done_wr = 1'b0;
        run(5);
        set_tbl(32'h78563412, 32'h78563412);
        done_wr = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (next_cap_idx(0) == 2) hit = 1'b1;
            else tick();
        end
        chk("rst_reach_elem2", 0, 32'(hit), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        done_wr = 1'b0;
        run(1);
        reset_n = 1'b1;
        run(2);
        done_wr = 1'b1;
        run(14);
        chk("post_rst_vec",   0, d_vec[0],        32'h78563412);
        chk("post_rst_vec",   1, d_vec[1],        32'h78563412);
        chk("post_rst_valid", 0, 32'(d_valid[0]), 32'd1);

        // Accept and load on the same edge as the last element.
        done_wr = 1'b0;
        run(5);
        set_tbl(32'hF0DEBC9A, 32'hF0DEBC9A);
        done_wr = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 25 && !hit; k++) begin
            hit = (next_cap_idx(0) == F - 1);
            h_ready = hit;
            tick();
        end
        h_ready = 1'b0;
        chk("simul_reached", 0, 32'(hit),         32'd1);
        chk("simul_no_pend", 0, 32'(d_busy[0]),   32'd0);
        chk("simul_valid",   0, 32'(d_valid[0]),  32'd1);
        chk("simul_vec",     0, d_vec[0],         32'hF0DEBC9A);

        // Randomized traffic with alternating light/heavy backpressure.
        use_tbl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) done_wr = ~done_wr;
            if (((k / 200) % 2) == 0) h_ready = ($urandom_range(0, 3) != 0);
            else                      h_ready = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lstm_h_collector.md
Name: lstm_h_collector

Overview:
Downstream stage of lstm_cell, clocked on sys_clk. On each rising edge of done_wr it requests the hidden state by pulsing read_output. It then deserializes FEATURES elements from h_curr_ser into one packed h_t vector. The vector is offered to the next layer (dense stage or h feedback path) through a valid/ready handshake, and a shadow register allows one further capture while the output slot is occupied.

Parameters:
FEATURES, 4, elements per hidden-state vector
ELEMENT_BITS, 8, bits per element
RD_PULSE, 4, sys_clk cycles read_output is held high
RD_LAT, 1, sys_clk cycles from first read_output-high cycle to first valid h_curr_ser element

Ports:
sys_clk  in  1  system clock; sole clock of the block
reset_n  in  1  asynchronous active-low reset
done_wr  in  1  level from lstm_cell, cell_clk domain; a rising edge means h_t is ready
read_output  out  1  request to lstm_cell to stream h_t
h_curr_ser  in  ELEMENT_BITS  serial h_t element, one per sys_clk, element 0 first
h_vec  out  FEATURES*ELEMENT_BITS  assembled h_t; element i at bits [i*EB +: EB]
h_valid  out  1  h_vec holds an unconsumed vector
h_ready  in  1  consumer accepts h_vec when h_valid&&h_ready
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: read_output=0, h_valid=0, h_vec=0, busy=0, shadow=0, all counters=0, FSM=IDLE, sync flops=0.
- done_wr synchronization: passes through a 2-flop synchronizer, then a rising-edge detector on the synced signal. This produces rise, a one-cycle pulse, 3 cycles after done_wr is first sampled high.
- FSM states: IDLE, REQ, CAPT, PEND.
- IDLE:
  - On rise, go to REQ.
  - read_output goes high on the next cycle, called cycle 0.
- REQ:
  - read_output stays high for exactly RD_PULSE cycles.
  - A cycle counter runs from cycle 0.
  - At cycle RD_LAT, go to CAPT. This may happen while read_output is still high; the pulse still completes its full length.
  - RD_LAT=0 is legal: capture starts at cycle 0.
- CAPT:
  - Sample h_curr_ser on FEATURES consecutive cycles into the shadow register, element index 0..FEATURES-1.
  - After the last element, transfer as described below.
- Transfer from shadow to output:
  - If h_valid=0, or h_valid&&h_ready in that same cycle, load h_vec from the shadow, set h_valid=1 on the next edge, and return to IDLE.
  - Otherwise go to PEND.
- PEND: hold the shadow. When the output slot frees (h_valid&&h_ready, or h_valid=0), load h_vec, keep h_valid=1, and go to IDLE.
- Output handshake:
  - h_valid&&h_ready with no pending load: h_valid clears on the next edge.
  - h_vec is stable while h_valid=1 and h_ready=0.
- Overrun: a rise seen in any state other than IDLE is dropped. No second request is issued and the captured data is unaffected.
- Simultaneous rise and return-to-IDLE in the same cycle: the rise is dropped, because the state is not yet IDLE when it is evaluated.
- Throughput: one vector per (3 + RD_LAT + FEATURES + 1) cycles, minimum, with no backpressure.
- Reset asserted mid-operation: all state clears immediately. read_output drops asynchronously, and any partial vector is discarded.
- Arithmetic: counters are sized $clog2 of max(RD_PULSE, RD_LAT+1, FEATURES)+1. No arithmetic is applied to data; elements are packed unmodified.

Optional Feature:
LSTM_HCOL_OVF_CNT_EN
- Defined: adds output port ovf_cnt [7:0].
  - Increments on each dropped rise.
  - Saturates at 8'hFF and does not wrap.
  - Reset value 0.
- Undefined: no port is added, and dropped rises are silently ignored.

Decomposition:
- Shared package lstm_pkg holds:
  - FEATURES and ELEMENT_BITS defaults
  - the hcol_state_t enum {IDLE, REQ, CAPT, PEND}
  - the element typedef logic [ELEMENT_BITS-1:0]
- One sub-module, lstm_sync2: a 2-flop synchronizer plus rising-edge detector, async active-low reset, outputs the rise pulse. It is reusable for done_w1 and done_w2.

Test Plan:
- Basic capture:
  - Stimulus: reset 90 ns, then done_wr 0→1; h_curr_ser = 8'h11, 22, 33, 44 on capture cycles 1..4 after read_output rises.
  - Response: read_output high 4 cycles, h_vec=32'h44332211, h_valid=1; with h_ready=1 for one cycle, h_valid returns to 0.
- Backpressure:
  - Stimulus: hold h_ready=0; second done_wr pulse with data AA,BB,CC,DD.
  - Response: FSM reaches PEND and h_vec stays 32'h44332211. After h_ready=1 for one cycle, h_vec=32'hDDCCBBAA and h_valid=1.
- Overrun:
  - Stimulus: toggle done_wr 0→1→0→1 during CAPT.
  - Response: only one read_output pulse; h_vec matches the first stream; ovf_cnt=1 when LSTM_HCOL_OVF_CNT_EN is defined.
- Reset mid-CAPT:
  - Stimulus: assert reset_n=0 after 2 elements.
  - Response: read_output, h_valid, h_vec and busy are all 0 immediately; the next request captures cleanly.
- Simultaneous accept and load:
  - Stimulus: h_valid=1 with h_ready=1 in the same cycle as the last element.
  - Response: h_vec updates to the new vector, h_valid stays 1, and there is no PEND visit.
- RD_LAT=0, RD_PULSE=1 instance:
  - Stimulus: 8'h01, 02, 03, 04 starting at cycle 0.
  - Response: h_vec=32'h04030201, read_output high exactly 1 cycle.
